booth_mul_arbiter: RTL

Round-robin arbiter and sequencer that shares one signed Booth multiplier (the 32x32 -> 64 unit with the `run`/`isValid` handshake) among NUM_REQ requesters. It accepts one operand pair at a time, drives the multiplier's run level, captures the result, returns it on a shared response bus tagged with the requester index, and re-arms the multiplier before the next grant. A watchdog aborts an operation whose `isValid` never arrives. The block sits between client logic and the single multiplier instance.

---
 rtl/booth_mul_arbiter_if.sv | 37 +++
 rtl/booth_mul_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/booth_mul_arbiter_if.sv
// Bundle of requester, response and multiplier-side signals around the shared Booth multiplier.
// The slave modport is the arbiter; the master modport is the surrounding client/multiplier logic.
interface booth_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_multiplicand;
  logic [NUM_REQ*WIDTH-1:0] req_multiplier;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [2*WIDTH-1:0]       rsp_result;
  logic                     rsp_err;

  logic [WIDTH-1:0]         mul_multiplicand;
  logic [WIDTH-1:0]         mul_multiplier;
  logic                     mul_run;
  logic                     mul_isValid;
  logic [2*WIDTH-1:0]       mul_result;

  modport slave (
    input  req_valid, req_multiplicand, req_multiplier, rsp_ready, mul_isValid, mul_result,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
           mul_multiplicand, mul_multiplier, mul_run
  );

  modport master (
    output req_valid, req_multiplicand, req_multiplier, rsp_ready, mul_isValid, mul_result,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
           mul_multiplicand, mul_multiplier, mul_run
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// Round-robin sharing of one Booth multiplier among NUM_REQ requesters, with a RUN-phase
// watchdog and a one-cycle DRAIN so the multiplier sees run low before the next operation.
module booth_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  booth_mul_arbiter_if.slave   bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, RUN, RSP, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     last_grant_q;
  logic [IDW-1:0]     grant_idx;
  logic               grant_any;
  logic [NUM_REQ-1:0] grant_oh;
  logic [CW-1:0]      cnt_q;
  logic               timeout_hit;

  logic [WIDTH-1:0]   mul_a_q, mul_b_q;
  logic [IDW-1:0]     rsp_id_q;
  logic [2*WIDTH-1:0] rsp_result_q;
  logic               rsp_err_q;

  logic [WIDTH-1:0]   cand_sl  [NUM_REQ];
  logic [WIDTH-1:0]   plier_sl [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign cand_sl[gi]  = bus.req_multiplicand[gi*WIDTH +: WIDTH];
      assign plier_sl[gi] = bus.req_multiplier[gi*WIDTH +: WIDTH];
      assign grant_oh[gi] = grant_any && (grant_idx == IDW'(gi));
    end
  endgenerate

  // Scan from farthest to nearest offset so the nearest requester after last_grant wins.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      idx = (int'(last_grant_q) + off) % NUM_REQ;
      if (bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = RUN;
      RUN:     if (bus.mul_isValid || timeout_hit) state_d = RSP;
      RSP:     if (bus.rsp_ready) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    bus.mul_run   = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state_q)
      IDLE:    bus.req_ready = rst_n ? grant_oh : '0;
      RUN:     bus.mul_run   = 1'b1;
      RSP:     bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // isValid takes priority over the watchdog when both land on the final RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      cnt_q        <= '0;
      last_grant_q <= IDW'(NUM_REQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            mul_a_q      <= cand_sl[grant_idx];
            mul_b_q      <= plier_sl[grant_idx];
            rsp_id_q     <= grant_idx;
            last_grant_q <= grant_idx;
            cnt_q        <= '0;
          end
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (bus.mul_isValid) begin
            rsp_result_q <= bus.mul_result;
            rsp_err_q    <= 1'b0;
          end else if (timeout_hit) begin
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mul_multiplicand = mul_a_q;
  assign bus.mul_multiplier   = mul_b_q;
  assign bus.rsp_id           = rsp_id_q;
  assign bus.rsp_result       = rsp_result_q;
  assign bus.rsp_err          = rsp_err_q;
endmodule
